// File: rtl/button_event_conditioner_pkg.sv
// Shared definitions for the push-button conditioner.
//   - Default timing constants for a 50 MHz clock.
//   - Repeat FSM state encoding.
//   - Small constant helper used to size the repeat counter.
package button_event_conditioner_pkg;

    localparam int unsigned DefDebounceCycles = 1_000_000;   // 20 ms
    localparam int unsigned DefRepeatDelay    = 25_000_000;  // 500 ms
    localparam int unsigned DefRepeatRate     = 5_000_000;   // 100 ms

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StRepeat = 2'd2
    } rep_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_conditioner_button_channel.sv
// One push-button channel: 2-flop synchronizer, debounce counter, registered
// press/release pulses and an auto-repeat FSM.
// Ports:
//   clk_i      system clock
//   reset_i    synchronous, active-high reset
//   button_ni  raw button level, active-low, asynchronous
//   level_o    debounced level, active-high
//   press_o    one-cycle pulse in the first cycle level_o is 1
//   release_o  one-cycle pulse in the first cycle level_o is 0
//   repeat_o   one-cycle auto-repeat pulse while held
module button_channel
    import button_event_conditioner_pkg::*;
#(
    parameter int unsigned DebounceCycles = DefDebounceCycles,
    parameter int unsigned RepeatDelay    = DefRepeatDelay,
    parameter int unsigned RepeatRate     = DefRepeatRate
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic button_ni,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int unsigned DbW  = $clog2(DebounceCycles + 1);
    localparam int unsigned RepW = $clog2(max_u(RepeatDelay, RepeatRate) + 1);

    localparam logic [DbW-1:0]  DbLast    = DbW'(DebounceCycles - 1);
    localparam logic [RepW-1:0] DelayLast = RepW'(RepeatDelay - 1);
    localparam logic [RepW-1:0] RateLast  = RepW'(RepeatRate - 1);

    logic [1:0]     sync_q, sync_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic           repeat_q, repeat_d;
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    rep_state_e     state_q, state_d;

    logic pressed_sync;
    logic db_differ;
    logic db_accept;

    always_comb begin
        sync_d       = {sync_q[0], button_ni};
        pressed_sync = ~sync_q[1];

        // Level changes only after DebounceCycles consecutive disagreeing cycles.
        db_differ = (pressed_sync != level_q);
        db_accept = db_differ && (db_cnt_q == DbLast);
        db_cnt_d  = (db_differ && !db_accept) ? db_cnt_q + 1'b1 : '0;
        level_d   = level_q ^ db_accept;

        // Pulses are computed with the level update so they line up with it.
        press_d   = db_accept && !level_q;
        release_d = db_accept && level_q;

        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        repeat_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (press_d) begin
                    state_d   = StDelay;
                    rep_cnt_d = '0;
                end
            end
            StDelay: begin
                if (rep_cnt_q == DelayLast) begin
                    repeat_d  = 1'b1;
                    rep_cnt_d = '0;
                    state_d   = StRepeat;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
            StRepeat: begin
                if (rep_cnt_q == RateLast) begin
                    repeat_d  = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                rep_cnt_d = '0;
            end
        endcase

        // Release wins over a repeat scheduled for the same cycle.
        if (release_d) begin
            state_d   = StIdle;
            rep_cnt_d = '0;
            repeat_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q    <= 2'b11;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            rep_cnt_q <= '0;
            state_q   <= StIdle;
        end else begin
            sync_q    <= sync_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            rep_cnt_q <= rep_cnt_d;
            state_q   <= state_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_event_conditioner.sv
// Conditioner for the DE0-CV push buttons: turns raw active-low bouncing
// levels into clean active-high levels and one-cycle press/release/repeat
// pulses, one independent channel per button.
// Ports:
//   in_clk       system clock (50 MHz)
//   in_reset     synchronous, active-high reset
//   in_button    raw button levels, active-low, asynchronous
//   out_level    debounced levels, active-high
//   out_press    one-cycle pulse on accepted press
//   out_release  one-cycle pulse on accepted release
//   out_repeat   one-cycle auto-repeat pulse while held
//   out_step     out_press | out_repeat, for up/down stepping
module button_event_conditioner
    import button_event_conditioner_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
    parameter int unsigned REPEAT_RATE     = DefRepeatRate
) (
    input  logic                   in_clk,
    input  logic                   in_reset,
    input  logic [NUM_BUTTONS-1:0] in_button,
    output logic [NUM_BUTTONS-1:0] out_level,
    output logic [NUM_BUTTONS-1:0] out_press,
    output logic [NUM_BUTTONS-1:0] out_release,
    output logic [NUM_BUTTONS-1:0] out_repeat,
    output logic [NUM_BUTTONS-1:0] out_step
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        button_channel #(
            .DebounceCycles (DEBOUNCE_CYCLES),
            .RepeatDelay    (REPEAT_DELAY),
            .RepeatRate     (REPEAT_RATE)
        ) u_chan (
            .clk_i     (in_clk),
            .reset_i   (in_reset),
            .button_ni (in_button[i]),
            .level_o   (out_level[i]),
            .press_o   (out_press[i]),
            .release_o (out_release[i]),
            .repeat_o  (out_repeat[i])
        );
    end

    assign out_step = out_press | out_repeat;

endmodule

// File: tb/tb_button_event_conditioner.sv
// Scoreboard bench for button_event_conditioner with short timing parameters.
module tb_button_event_conditioner;

    localparam int unsigned NB = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RR = 3;

    localparam int EvPress   = 0;
    localparam int EvRelease = 1;
    localparam int EvRepeat  = 2;
    localparam int EvReset   = 3;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn;
    logic [NB-1:0] level, press, release_p, repeat_p, step;

    ev_t     sb_q[$];
    int      cyc = 0;
    int      n_vec = 0;
    int      n_err = 0;
    bit      mon_en = 1'b0;
    logic [NB-1:0] exp_level = '0;

    button_event_conditioner #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .in_clk      (clk),
        .in_reset    (rst),
        .in_button   (btn),
        .out_level   (level),
        .out_press   (press),
        .out_release (release_p),
        .out_repeat  (repeat_p),
        .out_step    (step)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic push_ev(input int c, input int ch, input int kind);
        ev_t e;
        e.cyc  = c;
        e.ch   = ch;
        e.kind = kind;
        sb_q.push_back(e);
    endtask

    // Returns just after the active edge that starts cycle n.
    task automatic at_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pops every expectation due this cycle and compares all outputs.
    always @(negedge clk) begin
        ev_t e;
        logic [NB-1:0] ep, er, et;
        if (mon_en) begin
            ep = '0;
            er = '0;
            et = '0;
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                case (e.kind)
                    EvPress: begin
                        ep[e.ch]        = 1'b1;
                        exp_level[e.ch] = 1'b1;
                    end
                    EvRelease: begin
                        er[e.ch]        = 1'b1;
                        exp_level[e.ch] = 1'b0;
                    end
                    EvRepeat: et[e.ch] = 1'b1;
                    default:  exp_level = '0;
                endcase
            end
            check_eq("level", level, exp_level);
            check_eq("press", press, ep);
            check_eq("release", release_p, er);
            check_eq("repeat", repeat_p, et);
            check_eq("step", step, ep | et);
        end
    end

    initial begin
        rst = 1'b1;
        btn = '1;
        at_cycle(1);
        mon_en = 1'b1;
        at_cycle(3);
        rst = 1'b0;

        // Clean press held 8 cycles, then released before any repeat.
        push_ev(16, 2, EvPress);
        push_ev(24, 2, EvRelease);
        at_cycle(10);
        btn[2] = 1'b0;
        at_cycle(18);
        btn[2] = 1'b1;

        // Bounce shorter than the debounce window: nothing happens.
        at_cycle(40);
        btn[1] = 1'b0;
        at_cycle(43);
        btn[1] = 1'b1;

        // Auto-repeat, then release landing on a scheduled repeat (85).
        push_ev(66, 2, EvPress);
        push_ev(76, 2, EvRepeat);
        push_ev(79, 2, EvRepeat);
        push_ev(82, 2, EvRepeat);
        push_ev(85, 2, EvRelease);
        at_cycle(60);
        btn[2] = 1'b0;
        at_cycle(79);
        btn[2] = 1'b1;

        // Reset while in repeat and still held; press re-accepted afterwards.
        push_ev(106, 2, EvPress);
        push_ev(116, 2, EvRepeat);
        push_ev(119, 2, EvRepeat);
        push_ev(122, 2, EvRepeat);
        push_ev(124, 0, EvReset);
        push_ev(130, 2, EvPress);
        push_ev(140, 2, EvRepeat);
        push_ev(143, 2, EvRepeat);
        push_ev(146, 2, EvRepeat);
        push_ev(149, 2, EvRepeat);
        push_ev(150, 2, EvRelease);
        at_cycle(100);
        btn[2] = 1'b0;
        at_cycle(123);
        rst = 1'b1;
        at_cycle(124);
        rst = 1'b0;
        at_cycle(144);
        btn[2] = 1'b1;

        // Simultaneous presses on channels 1 and 3.
        push_ev(176, 1, EvPress);
        push_ev(176, 3, EvPress);
        push_ev(184, 1, EvRelease);
        push_ev(184, 3, EvRelease);
        at_cycle(170);
        btn[1] = 1'b0;
        btn[3] = 1'b0;
        at_cycle(178);
        btn[1] = 1'b1;
        btn[3] = 1'b1;

        at_cycle(200);
        @(negedge clk);
        check_eq("sb_left", NB'(sb_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
